// File: rtl/traffic_light_ctrl_pkg.sv
// Shared definitions for the NS/EW traffic-light sequencer.
//   state_t         : phase encodings (NS_G=0 .. AR2=5)
//   LT_RED/YEL/GRN  : one-hot {R,Y,G} lamp codes
//   ha_sum/ha_carry : half-adder cell (S = q^c, C = q&c) used by the phase timer
//   next_phase, is_green, is_ar, ns_code, ew_code : phase helpers
package traffic_light_ctrl_pkg;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5
  } state_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  function automatic logic ha_sum(input logic q, input logic c);
    return q ^ c;
  endfunction

  function automatic logic ha_carry(input logic q, input logic c);
    return q & c;
  endfunction

  // Illegal encodings fall back to the all-red clearance phase.
  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      NS_G:    n = NS_Y;
      NS_Y:    n = AR1;
      AR1:     n = EW_G;
      EW_G:    n = EW_Y;
      EW_Y:    n = AR2;
      AR2:     n = NS_G;
      default: n = AR2;
    endcase
    return n;
  endfunction

  function automatic logic is_green(input state_t s);
    return (s == NS_G) || (s == EW_G);
  endfunction

  function automatic logic is_ar(input state_t s);
    return (s == AR1) || (s == AR2);
  endfunction

  function automatic logic [2:0] ns_code(input state_t s);
    logic [2:0] c;
    case (s)
      NS_G:    c = LT_GRN;
      NS_Y:    c = LT_YEL;
      default: c = LT_RED;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] ew_code(input state_t s);
    logic [2:0] c;
    case (s)
      EW_G:    c = LT_GRN;
      EW_Y:    c = LT_YEL;
      default: c = LT_RED;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Phase timer: CNT_W-bit tick counter whose incrementer is a ripple chain of
// half-adder cells with carry-in tied to 1.
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset, clears the count
//   tick  in  advance strobe
//   clear in  return to zero on this tick instead of incrementing
//   count out current count
module traffic_light_ctrl_phase_timer
  import traffic_light_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] inc_s;
  logic [CNT_W-1:0] carry_s;

  assign carry_s[0] = 1'b1;

  // The carry out of the top cell is never needed, so only CNT_W-1 carries
  // are generated.
  for (genvar i = 0; i < CNT_W; i++) begin : g_ha
    assign inc_s[i] = ha_sum(count_r[i], carry_s[i]);
    if (i < CNT_W - 1) begin : g_carry
      assign carry_s[i+1] = ha_carry(count_r[i], carry_s[i]);
    end
  end

  // Count register: clear or increment on tick, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (tick && clear) begin
      count_r <= '0;
    end else if (tick) begin
      count_r <= inc_s;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way (NS/EW) traffic-light sequencer with a pedestrian walk phase.
// Phases NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G, advanced only
// on the one-clock 'tick' strobe.
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset
//   tick       in  advance strobe, one clk wide
//   ped_req    in  pedestrian button level
//   ns_light   out {R,Y,G} one-hot, NS direction
//   ew_light   out {R,Y,G} one-hot, EW direction
//   walk       out pedestrian walk lamp
//   state_o    out current state encoding (debug)
//   phase_done out one-clk pulse on every state change
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int RED_TICKS    = 2,
  parameter int WALK_TICKS   = 4,
  parameter int MIN_GREEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] state_o,
  output logic       phase_done
);

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] CUT_MIN     = CNT_W'(MIN_GREEN - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic             ped_pending_r;
  logic             pending_next_s;
  logic             walk_r;
  logic             walk_next_s;
  logic             phase_done_r;
  logic [2:0]       ns_light_r;
  logic [2:0]       ew_light_r;
  logic             walk_out_r;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] dur_last_s;
  logic             cut_s;
  logic             adv_s;
  logic             enter_ar_s;

  traffic_light_ctrl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .clear (adv_s),
    .count (count_s)
  );

  // Last count value of the current phase; clearance length depends on walk.
  always_comb begin
    dur_last_s = RED_LAST;
    case (state_r)
      NS_G, EW_G: dur_last_s = GREEN_LAST;
      NS_Y, EW_Y: dur_last_s = YELLOW_LAST;
      AR1, AR2:   dur_last_s = walk_r ? WALK_LAST : RED_LAST;
      default:    dur_last_s = RED_LAST;
    endcase
  end

  // Phase advance, pedestrian bookkeeping and next-state selection.
  always_comb begin
    cut_s          = is_green(state_r) && ped_pending_r && (count_s >= CUT_MIN);
    adv_s          = tick && ((count_s == dur_last_s) || cut_s);
    next_state_s   = state_r;
    pending_next_s = ped_pending_r;
    walk_next_s    = walk_r;

    if (adv_s) begin
      next_state_s = next_phase(state_r);
    end else begin
      next_state_s = state_r;
    end

    enter_ar_s = adv_s && is_ar(next_state_s);

    // A request on the AR entry clock is served by this walk, not queued.
    // During a walk clearance the button is ignored.
    if (enter_ar_s) begin
      pending_next_s = 1'b0;
    end else if (ped_req && !(is_ar(state_r) && walk_r)) begin
      pending_next_s = 1'b1;
    end else begin
      pending_next_s = ped_pending_r;
    end

    if (enter_ar_s) begin
      walk_next_s = ped_pending_r | ped_req;
    end else if (adv_s) begin
      walk_next_s = 1'b0;
    end else begin
      walk_next_s = walk_r;
    end
  end

  // State, pedestrian and output registers; outputs decode the next state so
  // they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= AR2;
      ped_pending_r <= 1'b0;
      walk_r        <= 1'b0;
      phase_done_r  <= 1'b0;
      ns_light_r    <= LT_RED;
      ew_light_r    <= LT_RED;
      walk_out_r    <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      ped_pending_r <= pending_next_s;
      walk_r        <= walk_next_s;
      phase_done_r  <= adv_s;
      ns_light_r    <= ns_code(next_state_s);
      ew_light_r    <= ew_code(next_state_s);
      walk_out_r    <= walk_next_s & is_ar(next_state_s);
    end
  end

  assign ns_light   = ns_light_r;
  assign ew_light   = ew_light_r;
  assign walk       = walk_out_r;
  assign state_o    = state_r;
  assign phase_done = phase_done_r;

endmodule
